add_sub_seq_ctrl: RTL and testbench

- Clocked, parametrised control sequencer for the word-serial adder/subtractor datapath.
- Operands are WORDS bus beats wide. Sequence per transaction: load M, load Q, word-serial compute (low word first, carry chained), then drive the result onto the outbus (high word first).
- Drives the shared control vector c[10:0] and a word index to the datapath.
- Registered Moore FSM. Adds start/busy/done handshake and synchronous abort on enable low.

---
 rtl/add_sub_pkg.sv | 23 ++
 rtl/seq_word_cnt.sv | 21 ++
 rtl/add_sub_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_add_sub_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared state type and control-vector bit map for the add/sub sequencer.
package add_sub_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_LOAD_Q = 3'd2,
        S_CALC   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam int CW         = 11;
    localparam int C_LD_M     = 0;
    localparam int C_LD_Q     = 1;
    localparam int C_CIN      = 2;
    localparam int C_INV      = 3;
    localparam int C_WR       = 4;
    localparam int C_CARRY    = 5;
    localparam int C_OUTB     = 7;
    localparam int C_LAST_OUT = 8;

    // Bits that keep their value while the sequencer is stalled.
    localparam logic [CW-1:0] C_STALL_KEEP = CW'((1 << C_INV) | (1 << C_OUTB));
endpackage

// File: rtl/seq_word_cnt.sv
// seq_word_cnt: word index counter with synchronous load, increment and decrement.
module seq_word_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_cnt <= '0;
        else        r_cnt <= i_ld ? i_ld_val : i_inc ? r_cnt + 1'b1 : i_dec ? r_cnt - 1'b1 : r_cnt;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/add_sub_seq_ctrl.sv
// add_sub_seq_ctrl: Moore sequencer for the word-serial adder/subtractor (load M, load Q, calc, out).
// Optional stall input enabled by ADD_SUB_SEQ_STALL_EN.
module add_sub_seq_ctrl
    import add_sub_pkg::*;
#(
    parameter  int WORDS = 2,
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
`ifdef ADD_SUB_SEQ_STALL_EN
    input  logic            stall,
`endif
    input  logic            clk,
    input  logic            rst_b,
    input  logic            enable,
    input  logic            start,
    input  logic            op,
    output logic            busy,
    output logic            done,
    output logic [IDXW-1:0] word_idx,
    output logic [CW-1:0]   c
);
    localparam logic [IDXW-1:0] L_LAST = IDXW'(WORDS - 1);

    state_t          r_state, w_state_nx;
    logic            r_op, w_op_nx;
    logic            w_ld, w_inc, w_dec, w_stall, w_up_last, w_dn_last;
    logic [IDXW-1:0] w_ld_val;
    logic [CW-1:0]   w_c;

`ifdef ADD_SUB_SEQ_STALL_EN
    assign w_stall = stall & enable;
`else
    assign w_stall = 1'b0;
`endif

    assign w_up_last = word_idx == L_LAST;
    assign w_dn_last = word_idx == '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_ld       = 1'b0;
        w_ld_val   = '0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        if (!enable) begin
            w_state_nx = S_IDLE;
            w_ld       = 1'b1;
        end else if (!w_stall) begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_state_nx = S_LOAD_M;
                    w_op_nx    = op;
                    w_ld       = 1'b1;
                end
                S_LOAD_M: begin
                    w_state_nx = w_up_last ? S_LOAD_Q : S_LOAD_M;
                    w_ld       = w_up_last;
                    w_inc      = !w_up_last;
                end
                S_LOAD_Q: begin
                    w_state_nx = w_up_last ? S_CALC : S_LOAD_Q;
                    w_ld       = w_up_last;
                    w_inc      = !w_up_last;
                end
                S_CALC: begin
                    // Output phase walks the words high to low.
                    w_state_nx = w_up_last ? S_OUT : S_CALC;
                    w_ld       = w_up_last;
                    w_ld_val   = L_LAST;
                    w_inc      = !w_up_last;
                end
                S_OUT: begin
                    w_state_nx = w_dn_last ? S_IDLE : S_OUT;
                    w_ld       = w_dn_last;
                    w_dec      = !w_dn_last;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_ld       = 1'b1;
                end
            endcase
        end
    end

    seq_word_cnt #(.W(IDXW)) u_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_ld     (w_ld),
        .i_ld_val (w_ld_val),
        .i_inc    (w_inc),
        .i_dec    (w_dec),
        .o_cnt    (word_idx)
    );

    assign busy = r_state != S_IDLE;
    assign done = (r_state == S_OUT) & w_dn_last & !w_stall;

    always_comb begin
        w_c             = '0;
        w_c[C_LD_M]     = r_state == S_LOAD_M;
        w_c[C_LD_Q]     = r_state == S_LOAD_Q;
        w_c[C_CIN]      = (r_state == S_CALC) & !w_dn_last;
        w_c[C_INV]      = r_op & busy;
        w_c[C_WR]       = r_state == S_CALC;
        w_c[C_CARRY]    = (r_state == S_CALC) & w_up_last;
        w_c[C_OUTB]     = r_state == S_OUT;
        w_c[C_LAST_OUT] = (r_state == S_OUT) & w_dn_last;
        if (w_stall) w_c = w_c & C_STALL_KEEP;
    end

    assign c = w_c;
endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// tb_add_sub_seq_ctrl: scoreboard bench driving WORDS=1, 2 and 4 sequencers from shared stimulus.
module tb_add_sub_seq_ctrl;
    typedef struct packed {
        logic [10:0] c;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } beat_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic enable = 1'b0;
    logic start = 1'b0;
    logic op = 1'b0;
`ifdef ADD_SUB_SEQ_STALL_EN
    logic stall = 1'b0;
`endif
    logic        busy1, done1, busy2, done2, busy4, done4;
    logic [0:0]  idx1, idx2;
    logic [1:0]  idx4;
    logic [10:0] c1, c2, c4;

    int    checks = 0;
    int    failures = 0;
    beat_t q[$];
    beat_t e, a;

    always #5 clk = ~clk;

    add_sub_seq_ctrl #(.WORDS(1)) dut1 (
`ifdef ADD_SUB_SEQ_STALL_EN
        .stall(stall),
`endif
        .clk(clk), .rst_b(rst_b), .enable(enable), .start(start), .op(op),
        .busy(busy1), .done(done1), .word_idx(idx1), .c(c1));
    add_sub_seq_ctrl #(.WORDS(2)) dut2 (
`ifdef ADD_SUB_SEQ_STALL_EN
        .stall(stall),
`endif
        .clk(clk), .rst_b(rst_b), .enable(enable), .start(start), .op(op),
        .busy(busy2), .done(done2), .word_idx(idx2), .c(c2));
    add_sub_seq_ctrl #(.WORDS(4)) dut4 (
`ifdef ADD_SUB_SEQ_STALL_EN
        .stall(stall),
`endif
        .clk(clk), .rst_b(rst_b), .enable(enable), .start(start), .op(op),
        .busy(busy4), .done(done4), .word_idx(idx4), .c(c4));

    function automatic beat_t obs(int w);
        beat_t b;
        case (w)
            1:       b = '{c: c1, idx: 4'(idx1), busy: busy1, done: done1};
            4:       b = '{c: c4, idx: 4'(idx4), busy: busy4, done: done4};
            default: b = '{c: c2, idx: 4'(idx2), busy: busy2, done: done2};
        endcase
        return b;
    endfunction

    // Expected beat i (0..w-1) of phase ph (0=LOAD_M, 1=LOAD_Q, 2=CALC, 3=OUT).
    function automatic beat_t exp_beat(int w, int ph, int i, bit o);
        beat_t b;
        b      = '0;
        b.busy = 1'b1;
        b.idx  = 4'((ph == 3) ? w - 1 - i : i);
        case (ph)
            0: b.c[0] = 1'b1;
            1: b.c[1] = 1'b1;
            2: begin
                b.c[4] = 1'b1;
                b.c[2] = i != 0;
                b.c[5] = i == w - 1;
            end
            default: begin
                b.c[7] = 1'b1;
                b.c[8] = i == w - 1;
                b.done = i == w - 1;
            end
        endcase
        b.c[3] = o;
        return b;
    endfunction

    task automatic push_txn(int w, bit o);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < w; i++) q.push_back(exp_beat(w, p, i, o));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_b  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 1; w <= 4; w = w * 2) begin
            a = obs(w);
            checks++;
            if (a !== beat_t'(0)) begin
                failures++;
                $display("FAIL reset w=%0d: got c=%h idx=%0d busy=%b done=%b, want all 0", w, a.c, a.idx, a.busy, a.done);
            end
        end
        rst_b  = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_add();
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        push_txn(2, 1'b0);
        q.push_back('0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL add beat %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
    endtask

    task automatic test_sub();
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        push_txn(4, 1'b1);
        q.push_back('0);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            start = 1'b0;
            op    = 1'b0;
            e = q.pop_front();
            a = obs(4);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL sub beat %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
    endtask

    task automatic test_abort();
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        push_txn(2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL abort beat %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
        q.delete();
        enable = 1'b0;
        repeat (4) q.push_back('0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL abort idle %0d: got c=%h idx=%0d busy=%b done=%b, want all 0", k, a.c, a.idx, a.busy, a.done);
            end
        end
        start  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        repeat (3) begin
            push_txn(1, 1'b0);
            q.push_back('0);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            e = q.pop_front();
            a = obs(1);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL b2b beat %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_out();
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        push_txn(2, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL midrst beat %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
        q.delete();
        rst_b = 1'b0;
        #1;
        a = obs(2);
        checks++;
        if (a !== beat_t'(0)) begin
            failures++;
            $display("FAIL midrst async: got c=%h idx=%0d busy=%b done=%b, want all 0", a.c, a.idx, a.busy, a.done);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        push_txn(2, 1'b0);
        q.push_back('0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL midrst rerun %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
    endtask

`ifdef ADD_SUB_SEQ_STALL_EN
    task automatic test_stall();
        beat_t s;
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        push_txn(2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL stall pre %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
        stall = 1'b1;
        s = '{c: 11'h008, idx: 4'd1, busy: 1'b1, done: 1'b0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = obs(2);
            checks++;
            if (a !== s) begin
                failures++;
                $display("FAIL stall hold %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, s.c, s.idx, s.busy, s.done);
            end
        end
        stall = 1'b0;
        q.push_back('0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = q.pop_front();
            a = obs(2);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL stall post %0d: got c=%h idx=%0d busy=%b done=%b, want c=%h idx=%0d busy=%b done=%b",
                         k, a.c, a.idx, a.busy, a.done, e.c, e.idx, e.busy, e.done);
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_abort();
        test_back_to_back();
        test_reset_mid_out();
`ifdef ADD_SUB_SEQ_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
